// File: rtl/draw_sequencer_if.sv
// Bundles the frame trigger, per-layer draw handshakes, pixel streams and the
// single VGA write port seen by the draw sequencer.
interface draw_sequencer_if #(
    parameter int N_LAYERS = 4,
    parameter int LAYER_W  = 2
);
    logic                    frameStart;
    logic [N_LAYERS-1:0]     layerEn;
    logic [9*N_LAYERS-1:0]   layerX;
    logic [8*N_LAYERS-1:0]   layerY;
    logic [N_LAYERS-1:0]     start;
    logic [8:0]              xInit;
    logic [7:0]              yInit;
    logic [N_LAYERS-1:0]     drawDone;
    logic [8*N_LAYERS-1:0]   pixX;
    logic [7*N_LAYERS-1:0]   pixY;
    logic [8*N_LAYERS-1:0]   pixColour;
    logic [N_LAYERS-1:0]     pixWriteEn;
    logic [7:0]              vgaX;
    logic [6:0]              vgaY;
    logic [7:0]              vgaColour;
    logic                    vgaWriteEn;
    logic [LAYER_W-1:0]      layer;
    logic                    busy;
    logic                    frameDone;
    logic                    overrun;

    modport master (
        input  frameStart, layerEn, layerX, layerY, drawDone,
               pixX, pixY, pixColour, pixWriteEn,
        output start, xInit, yInit, vgaX, vgaY, vgaColour, vgaWriteEn,
               layer, busy, frameDone, overrun
    );

    modport slave (
        output frameStart, layerEn, layerX, layerY, drawDone,
               pixX, pixY, pixColour, pixWriteEn,
        input  start, xInit, yInit, vgaX, vgaY, vgaColour, vgaWriteEn,
               layer, busy, frameDone, overrun
    );
endinterface

// File: rtl/draw_sequencer.sv
// Frame scheduler: snapshots layer enables/positions on a frame trigger, then
// runs each enabled layer's draw in index order and muxes its pixels to VGA.
module draw_sequencer #(
    parameter int N_LAYERS = 4,
    parameter int LAYER_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    draw_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_READY   = 3'd2,
        S_DRAW    = 3'd3,
        S_RELEASE = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t                state_q;
    logic [LAYER_W-1:0]    layer_q;
    logic [LAYER_W-1:0]    layer_d;
    logic [N_LAYERS-1:0]   snap_en_q;
    logic [9*N_LAYERS-1:0] snap_x_q;
    logic [8*N_LAYERS-1:0] snap_y_q;
    logic [N_LAYERS-1:0]   start_q;
    logic [8:0]            x_init_q;
    logic [7:0]            y_init_q;
    logic [7:0]            vga_x_q;
    logic [6:0]            vga_y_q;
    logic [7:0]            vga_colour_q;
    logic                  vga_we_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic                  pending_q;
    logic                  overrun_q;

    logic                  en_sel;
    logic                  done_sel;
    logic                  we_sel;
    logic                  last_sel;
    logic [8:0]            x_sel;
    logic [7:0]            y_sel;
    logic [7:0]            px_sel;
    logic [6:0]            py_sel;
    logic [7:0]            pc_sel;
    logic [N_LAYERS-1:0]   onehot_sel;

    // View of the current layer's snapshot, handshake and pixel lanes
    always_comb begin
        en_sel     = 1'b0;
        done_sel   = 1'b0;
        we_sel     = 1'b0;
        x_sel      = 9'd0;
        y_sel      = 8'd0;
        px_sel     = 8'd0;
        py_sel     = 7'd0;
        pc_sel     = 8'd0;
        onehot_sel = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer_q == LAYER_W'(i)) begin
                en_sel        = snap_en_q[i];
                done_sel      = bus.drawDone[i];
                we_sel        = bus.pixWriteEn[i];
                x_sel         = snap_x_q[9*i +: 9];
                y_sel         = snap_y_q[8*i +: 8];
                px_sel        = bus.pixX[8*i +: 8];
                py_sel        = bus.pixY[7*i +: 7];
                pc_sel        = bus.pixColour[8*i +: 8];
                onehot_sel[i] = 1'b1;
            end else begin
                onehot_sel[i] = 1'b0;
            end
        end
    end

    assign last_sel = (layer_q == LAYER_W'(N_LAYERS - 1));
    assign layer_d  = layer_q + LAYER_W'(1);

    // Sequencer FSM, trigger queue and registered pixel mux
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            layer_q      <= '0;
            snap_en_q    <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            start_q      <= '0;
            x_init_q     <= 9'd0;
            y_init_q     <= 8'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 8'd0;
            vga_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            vga_x_q      <= px_sel;
            vga_y_q      <= py_sel;
            vga_colour_q <= pc_sel;
            vga_we_q     <= we_sel & (state_q == S_DRAW);

            // Only one trigger is queued; a second while queued is flagged
            if (bus.frameStart && (state_q != S_IDLE)) begin
                pending_q <= 1'b1;
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    overrun_q <= overrun_q;
                end
            end else begin
                pending_q <= pending_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.frameStart || pending_q) begin
                        snap_en_q <= bus.layerEn;
                        snap_x_q  <= bus.layerX;
                        snap_y_q  <= bus.layerY;
                        pending_q <= bus.frameStart & pending_q;
                        layer_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SCAN;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (en_sel) begin
                        x_init_q <= x_sel;
                        y_init_q <= y_sel;
                        state_q  <= S_READY;
                    end else if (last_sel) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_FINISH;
                    end else begin
                        layer_q <= layer_d;
                    end
                end
                S_READY: begin
                    // A done still high from the previous run must clear first
                    if (!done_sel) begin
                        start_q <= onehot_sel;
                        state_q <= S_DRAW;
                    end else begin
                        state_q <= S_READY;
                    end
                end
                S_DRAW: begin
                    if (done_sel) begin
                        start_q <= '0;
                        state_q <= S_RELEASE;
                    end else begin
                        state_q <= S_DRAW;
                    end
                end
                S_RELEASE: begin
                    if (!done_sel) begin
                        if (last_sel) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_FINISH;
                        end else begin
                            layer_q <= layer_d;
                            state_q <= S_SCAN;
                        end
                    end else begin
                        state_q <= S_RELEASE;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    start_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start      = start_q;
    assign bus.xInit      = x_init_q;
    assign bus.yInit      = y_init_q;
    assign bus.vgaX       = vga_x_q;
    assign bus.vgaY       = vga_y_q;
    assign bus.vgaColour  = vga_colour_q;
    assign bus.vgaWriteEn = vga_we_q;
    assign bus.layer      = layer_q;
    assign bus.busy       = busy_q;
    assign bus.frameDone  = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: behavioural draw models answer the
// start/done handshake, and each scenario task checks its own results.
module tb_draw_sequencer;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       model_on = 1'b0;
    logic [3:0] manual_done = 4'b0000;
    logic [3:0] model_done = 4'b0000;
    int         mcnt [N];
    int         checks = 0;
    int         failures = 0;

    logic       mon_clr = 1'b0;
    logic [3:0] prev_start = 4'b0000;
    logic [3:0] start_or = 4'b0000;
    logic [3:0] start_log [8];
    int         log_n = 0;
    int         fd_cnt = 0;

    draw_sequencer_if #(.N_LAYERS(N), .LAYER_W(2)) bus ();

    draw_sequencer #(.N_LAYERS(N), .LAYER_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.drawDone = model_on ? model_done : manual_done;

    // Draw model: raises done 3 cycles into a start, drops it once start falls
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!bus.start[i]) begin
                model_done[i] = 1'b0;
                mcnt[i] = 0;
            end else if (!model_done[i]) begin
                mcnt[i] = mcnt[i] + 1;
                if (mcnt[i] >= 3) model_done[i] = 1'b1;
            end
        end
    end

    // Records start-pulse order and frameDone pulses
    always @(negedge clk) begin
        if (mon_clr) begin
            log_n = 0; fd_cnt = 0; start_or = 4'b0000;
        end else begin
            if (bus.start != prev_start && bus.start != 4'b0000 && log_n < 8) begin
                start_log[log_n] = bus.start;
                log_n = log_n + 1;
            end
            if (bus.frameDone) fd_cnt = fd_cnt + 1;
            start_or = start_or | bus.start;
        end
        prev_start = bus.start;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        cyc(1);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frameStart = 1'b1;
        cyc(1);
        bus.frameStart = 1'b0;
    endtask

    task automatic wait_start(input logic [3:0] exp, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.start === exp) found = 1'b1;
            else cyc(1);
        end
        checks++;
        if (bus.start !== exp) begin
            failures++; $display("FAIL %s start got=%b exp=%b", name, bus.start, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (bus.busy === 1'b0) found = 1'b1;
            else cyc(1);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL %s busy timeout got=%b exp=0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        cyc(2);
        checks++;
        if (bus.start !== 4'b0000 || bus.vgaWriteEn !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got start=%b we=%b busy=%b exp 0", bus.start, bus.vgaWriteEn, bus.busy);
        end
        checks++;
        if (bus.frameDone !== 1'b0 || bus.overrun !== 1'b0 || bus.layer !== 2'd0) begin
            failures++; $display("FAIL reset_status got fd=%b ovr=%b layer=%0d exp 0", bus.frameDone, bus.overrun, bus.layer);
        end
        checks++;
        if (bus.xInit !== 9'd0 || bus.yInit !== 8'd0 || bus.vgaX !== 8'd0) begin
            failures++; $display("FAIL reset_data got x=%0d y=%0d vx=%0d exp 0", bus.xInit, bus.yInit, bus.vgaX);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_draw();
        model_on = 1'b1;
        bus.layerEn = 4'b0001;
        bus.pixWriteEn = 4'b0001;
        pulse_frame();
        cyc(1);
        pulse_frame();
        cyc(1);
        pulse_frame();
        wait_start(4'b0001, "rst_mid_start");
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++; $display("FAIL rst_mid_overrun got=%b exp=1", bus.overrun);
        end
        cyc(1);
        checks++;
        if (bus.vgaWriteEn !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_active got we=%b busy=%b exp 1/1", bus.vgaWriteEn, bus.busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.start !== 4'b0000 || bus.vgaWriteEn !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            failures++; $display("FAIL rst_async got start=%b we=%b busy=%b ovr=%b exp 0", bus.start, bus.vgaWriteEn, bus.busy, bus.overrun);
        end
        cyc(2);
        reset = 1'b0;
        cyc(2);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_pending_cleared busy got=%b exp=0", bus.busy);
        end
        pulse_frame();
        checks++;
        if (bus.busy !== 1'b1 || bus.layer !== 2'd0) begin
            failures++; $display("FAIL rst_fresh got busy=%b layer=%0d exp 1/0", bus.busy, bus.layer);
        end
        wait_start(4'b0001, "rst_fresh_start");
        wait_idle("rst_fresh_idle");
        bus.pixWriteEn = 4'b0000;
        cyc(2);
    endtask

    task automatic test_order();
        model_on = 1'b1;
        bus.layerEn = 4'b1011;
        bus.layerX = {9'd300, 9'd7, 9'd6, 9'd5};
        bus.layerY = {8'd200, 8'd3, 8'd2, 8'd1};
        clear_mon();
        pulse_frame();
        bus.layerX = {4{9'h1FF}};
        bus.layerY = {4{8'hFF}};
        wait_start(4'b0001, "order_l0");
        checks++;
        if (bus.xInit !== 9'd5 || bus.yInit !== 8'd1) begin
            failures++; $display("FAIL order_init0 got x=%0d y=%0d exp 5/1", bus.xInit, bus.yInit);
        end
        wait_start(4'b1000, "order_l3");
        checks++;
        if (bus.xInit !== 9'd300 || bus.yInit !== 8'd200) begin
            failures++; $display("FAIL order_init3 got x=%0d y=%0d exp 300/200", bus.xInit, bus.yInit);
        end
        wait_idle("order_idle");
        cyc(2);
        checks++;
        if (log_n !== 3 || start_log[0] !== 4'b0001 || start_log[1] !== 4'b0010 || start_log[2] !== 4'b1000) begin
            failures++; $display("FAIL order_seq got n=%0d %b %b %b exp 3 0001 0010 1000", log_n, start_log[0], start_log[1], start_log[2]);
        end
        checks++;
        if (start_or !== 4'b1011) begin
            failures++; $display("FAIL order_l2_never got=%b exp=1011", start_or);
        end
        checks++;
        if (fd_cnt !== 1 || bus.busy !== 1'b0 || bus.layer !== 2'd3) begin
            failures++; $display("FAIL order_done got fd=%0d busy=%b layer=%0d exp 1/0/3", fd_cnt, bus.busy, bus.layer);
        end
    endtask

    task automatic test_all_disabled();
        bus.layerEn = 4'b0000;
        clear_mon();
        pulse_frame();
        checks++;
        if (bus.busy !== 1'b1 || bus.frameDone !== 1'b0) begin
            failures++; $display("FAIL dis_accept got busy=%b fd=%b exp 1/0", bus.busy, bus.frameDone);
        end
        cyc(3);
        checks++;
        if (bus.frameDone !== 1'b0) begin
            failures++; $display("FAIL dis_early_fd got=%b exp=0", bus.frameDone);
        end
        cyc(1);
        checks++;
        if (bus.frameDone !== 1'b1 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL dis_fd_at5 got fd=%b busy=%b exp 1/1", bus.frameDone, bus.busy);
        end
        cyc(1);
        checks++;
        if (bus.frameDone !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL dis_after got fd=%b busy=%b exp 0/0", bus.frameDone, bus.busy);
        end
        cyc(1);
        checks++;
        if (start_or !== 4'b0000 || fd_cnt !== 1) begin
            failures++; $display("FAIL dis_nostart got start_or=%b fd=%0d exp 0000/1", start_or, fd_cnt);
        end
    endtask

    task automatic test_stale_done();
        model_on = 1'b0;
        manual_done = 4'b0001;
        bus.layerEn = 4'b0001;
        pulse_frame();
        cyc(4);
        checks++;
        if (bus.start !== 4'b0000) begin
            failures++; $display("FAIL stale_hold got=%b exp=0000", bus.start);
        end
        manual_done = 4'b0000;
        #0;
        checks++;
        if (bus.start !== 4'b0000) begin
            failures++; $display("FAIL stale_fall got=%b exp=0000", bus.start);
        end
        cyc(1);
        checks++;
        if (bus.start !== 4'b0001) begin
            failures++; $display("FAIL stale_rise got=%b exp=0001", bus.start);
        end
        manual_done = 4'b0001;
        cyc(1);
        checks++;
        if (bus.start !== 4'b0000) begin
            failures++; $display("FAIL stale_release got=%b exp=0000", bus.start);
        end
        manual_done = 4'b0000;
        wait_idle("stale_idle");
        model_on = 1'b1;
        cyc(2);
    endtask

    task automatic test_back_to_back();
        model_on = 1'b1;
        bus.layerEn = 4'b0001;
        clear_mon();
        pulse_frame();
        cyc(1);
        pulse_frame();
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++; $display("FAIL b2b_first_extra ovr got=%b exp=0", bus.overrun);
        end
        cyc(1);
        pulse_frame();
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++; $display("FAIL b2b_second_extra ovr got=%b exp=1", bus.overrun);
        end
        cyc(60);
        checks++;
        if (fd_cnt !== 2 || log_n !== 2 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL b2b_frames got fd=%0d starts=%0d busy=%b exp 2/2/0", fd_cnt, log_n, bus.busy);
        end
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++; $display("FAIL b2b_sticky ovr got=%b exp=1", bus.overrun);
        end
    endtask

    task automatic test_pixel_mux();
        model_on = 1'b1;
        bus.layerEn = 4'b0010;
        bus.pixX = {8'd0, 8'd0, 8'd42, 8'd99};
        bus.pixY = {7'd0, 7'd0, 7'd17, 7'd88};
        bus.pixColour = {8'h00, 8'h00, 8'hE0, 8'h1F};
        bus.pixWriteEn = 4'b0011;
        pulse_frame();
        wait_start(4'b0010, "pix_start");
        checks++;
        if (bus.vgaWriteEn !== 1'b0) begin
            failures++; $display("FAIL pix_pre_draw we got=%b exp=0", bus.vgaWriteEn);
        end
        cyc(1);
        checks++;
        if (bus.vgaX !== 8'd42 || bus.vgaY !== 7'd17 || bus.vgaColour !== 8'hE0 || bus.vgaWriteEn !== 1'b1) begin
            failures++; $display("FAIL pix_mux got x=%0d y=%0d c=%h we=%b exp 42/17/e0/1", bus.vgaX, bus.vgaY, bus.vgaColour, bus.vgaWriteEn);
        end
        wait_idle("pix_idle");
        cyc(1);
        checks++;
        if (bus.vgaWriteEn !== 1'b0) begin
            failures++; $display("FAIL pix_post we got=%b exp=0", bus.vgaWriteEn);
        end
        bus.pixWriteEn = 4'b0000;
    endtask

    initial begin
        bus.frameStart = 1'b0;
        bus.layerEn    = 4'b0000;
        bus.layerX     = '0;
        bus.layerY     = '0;
        bus.pixX       = '0;
        bus.pixY       = '0;
        bus.pixColour  = '0;
        bus.pixWriteEn = 4'b0000;
        test_reset();
        test_reset_mid_draw();
        test_order();
        test_all_disabled();
        test_stale_done();
        test_back_to_back();
        test_pixel_mux();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
